instrumented_adder_sequencer: RTL

On-chip measurement initiator that drives the instrumented adder's control inputs, so firmware no longer bit-bangs them over the logic analyser. On `start` it runs one or more integration windows: reset counters, load integration time, release the ring, enable counting, wait for `done`, stop the ring, capture the ring count. It accumulates the captures into one saturating sum and reports it with a valid flag. It sits between the CPU-facing register/LA shim and the adder instance.

---
 rtl/instrumented_adder_sequencer_if.sv | 33 +++
 rtl/instrumented_adder_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instrumented_adder_sequencer_if.sv
// Control/observation bus between the measurement sequencer and the
// instrumented adder: control strobes out, done flag and ring count back.
interface instrumented_adder_sequencer_if;
   logic        adder_reset;
   logic        adder_stop_b;
   logic        adder_counter_load;
   logic        adder_counter_enable;
   logic [31:0] adder_integration_time;
   logic        adder_done;
   logic [31:0] adder_ring_count;

   // Sequencer side: drives the adder controls, observes done and count.
   modport master (
      output adder_reset,
      output adder_stop_b,
      output adder_counter_load,
      output adder_counter_enable,
      output adder_integration_time,
      input  adder_done,
      input  adder_ring_count
   );

   // Adder side: consumes the controls, reports done and count.
   modport slave (
      input  adder_reset,
      input  adder_stop_b,
      input  adder_counter_load,
      input  adder_counter_enable,
      input  adder_integration_time,
      output adder_done,
      output adder_ring_count
   );
endinterface

// File: rtl/instrumented_adder_sequencer.sv
// Measurement initiator for the instrumented adder. Each run resets the
// adder, loads the integration time, lets the ring settle, counts until the
// adder reports done (or a timeout expires), stops the ring, waits for the
// count to drain and then adds it into a saturating accumulator.
module instrumented_adder_sequencer #(
   parameter int RUNS_W         = 8,
   parameter int ACC_W          = 40,
   parameter int SETTLE_CYCLES  = 4,
   parameter int DRAIN_CYCLES   = 2,
   parameter int TIMEOUT_MARGIN = 256
) (
   input  logic                           wb_clk_i,
   input  logic                           wb_rst_n_i,
   input  logic                           start,
   input  logic                           abort,
   input  logic [RUNS_W-1:0]              num_runs,
   input  logic [31:0]                    integration_time_i,
   output logic                           busy,
   output logic                           result_valid,
   output logic [ACC_W-1:0]               result_sum,
   output logic [RUNS_W-1:0]              runs_done,
   output logic                           timeout_err,
   instrumented_adder_sequencer_if.master adder
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RST,
      ST_LOAD,
      ST_SETTLE,
      ST_RUN,
      ST_DRAIN,
      ST_CAPT,
      ST_DONE,
      ST_ERROR
   } state_t;

   // Phase lengths expressed as the last value of the per-state cycle counter.
   localparam logic [32:0] RST_LAST    = 33'd1;
   localparam logic [32:0] SETTLE_LAST = 33'(SETTLE_CYCLES - 1);
   localparam logic [32:0] DRAIN_LAST  = 33'(DRAIN_CYCLES - 1);
   localparam logic [32:0] MARGIN      = 33'(TIMEOUT_MARGIN);

   state_t            state_reg;
   state_t            state_next;
   logic [32:0]       cnt_reg;
   logic [31:0]       itime_reg;
   logic [RUNS_W-1:0] runs_target_reg;
   logic [ACC_W-1:0]  sum_reg;
   logic [RUNS_W-1:0] runs_done_reg;
   logic              busy_reg;
   logic              valid_reg;
   logic              err_reg;
   logic              rst_out_reg;
   logic              stop_b_reg;
   logic              load_reg;
   logic              en_reg;

   logic              can_start;
   logic              start_ok;
   logic [RUNS_W-1:0] runs_eff;
   logic [RUNS_W-1:0] runs_done_inc;
   logic              last_run;
   logic [32:0]       run_elapsed;
   logic [32:0]       run_limit;
   logic              run_timeout;
   logic [ACC_W:0]    sum_wide;
   logic [ACC_W-1:0]  sum_sat;

   // Start is honoured only from the resting states, and never alongside abort.
   assign can_start = (state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                      (state_reg == ST_ERROR);
   assign start_ok  = start && can_start && !abort;

   // A request for zero runs still performs one measurement.
   assign runs_eff      = (num_runs == '0) ? RUNS_W'(1) : num_runs;
   assign runs_done_inc = runs_done_reg + RUNS_W'(1);
   assign last_run      = (runs_done_inc == runs_target_reg);

   // Timeout compare is 33 bits wide so integration time + margin cannot wrap.
   assign run_elapsed = cnt_reg + 33'd1;
   assign run_limit   = {1'b0, itime_reg} + MARGIN;
   assign run_timeout = (run_elapsed == run_limit);

   // One spare bit catches the carry that triggers saturation.
   assign sum_wide = {1'b0, sum_reg} + {{(ACC_W-31){1'b0}}, adder.adder_ring_count};
   assign sum_sat  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

   // Next-state selection; abort overrides every other transition.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) state_next = ST_RST;
         end
         ST_RST: begin
            if (cnt_reg == RST_LAST) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            state_next = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_reg == SETTLE_LAST) state_next = ST_RUN;
         end
         ST_RUN: begin
            // done beats a coincident timeout
            if (adder.adder_done)  state_next = ST_DRAIN;
            else if (run_timeout)  state_next = ST_ERROR;
         end
         ST_DRAIN: begin
            if (cnt_reg == DRAIN_LAST) state_next = ST_CAPT;
         end
         ST_CAPT: begin
            state_next = last_run ? ST_DONE : ST_RST;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (abort) state_next = ST_IDLE;
   end

   // State, phase counter, job config, accumulator and registered outputs.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         itime_reg       <= '0;
         runs_target_reg <= '0;
         sum_reg         <= '0;
         runs_done_reg   <= '0;
         busy_reg        <= 1'b0;
         valid_reg       <= 1'b0;
         err_reg         <= 1'b0;
         rst_out_reg     <= 1'b0;
         stop_b_reg      <= 1'b0;
         load_reg        <= 1'b0;
         en_reg          <= 1'b0;
      end else begin
         state_reg <= state_next;

         // Counter restarts on every state entry and idles in resting states.
         if (state_next != state_reg) begin
            cnt_reg <= '0;
         end else if (busy_reg) begin
            cnt_reg <= cnt_reg + 33'd1;
         end

         if (start_ok) begin
            itime_reg       <= integration_time_i;
            runs_target_reg <= runs_eff;
            sum_reg         <= '0;
            runs_done_reg   <= '0;
         end else if ((state_reg == ST_CAPT) && !abort) begin
            sum_reg       <= sum_sat;
            runs_done_reg <= runs_done_inc;
         end

         // Outputs are decoded from the state being entered so they line up
         // with the state register without a combinational decode.
         busy_reg    <= !(state_next inside {ST_IDLE, ST_DONE, ST_ERROR});
         valid_reg   <= (state_next == ST_DONE);
         err_reg     <= (state_next == ST_ERROR);
         rst_out_reg <= (state_next == ST_RST);
         load_reg    <= (state_next == ST_LOAD);
         stop_b_reg  <= (state_next == ST_SETTLE) || (state_next == ST_RUN);
         en_reg      <= (state_next == ST_RUN);
      end
   end

   assign busy         = busy_reg;
   assign result_valid = valid_reg;
   assign result_sum   = sum_reg;
   assign runs_done    = runs_done_reg;
   assign timeout_err  = err_reg;

   assign adder.adder_reset            = rst_out_reg;
   assign adder.adder_stop_b           = stop_b_reg;
   assign adder.adder_counter_load     = load_reg;
   assign adder.adder_counter_enable   = en_reg;
   assign adder.adder_integration_time = itime_reg;

endmodule
